// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - GPIO input synchroniser, debouncer, edge latch and IRQ for 13 pins
module gpio_irq (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wr_n,
  input  logic [2:0]  reg_addr_i,
  input  logic [7:0]  data_i,
  input  logic        irq_cs,
  output logic [7:0]  data_o,
  input  logic [12:0] gpio_in,
  output logic        irq_n
);

  logic [12:0] pend_q, pend_d;
  logic [12:0] en_q, en_d;
  logic [12:0] edge_sel_q, edge_sel_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [12:0] sync1_q, sync2_q;
  logic [12:0] s0_q, s0_d, s1_q, s1_d;
  logic [12:0] f_q, f_d;
  logic        irq_n_q, irq_n_d;

  logic        wr_en;
  logic        tick;
  logic [12:0] set_v;
  logic [12:0] clr_v;

  assign wr_en = irq_cs & ~wr_n;
  assign tick  = (cnt_q == presc_q);

  always_comb begin
    pend_d     = pend_q;
    en_d       = en_q;
    edge_sel_d = edge_sel_q;
    presc_d    = presc_q;
    cnt_d      = tick ? 8'd0 : cnt_q + 8'd1;
    s0_d       = s0_q;
    s1_d       = s1_q;
    f_d        = f_q;
    clr_v      = '0;
    set_v      = '0;

    // f rises on three high samples, falls on three low samples, else holds
    if (tick) begin
      s0_d = sync2_q;
      s1_d = s0_q;
      f_d  = (f_q | (s1_q & s0_q & sync2_q)) & (s1_q | s0_q | sync2_q);
    end

    set_v = (f_d & ~f_q & ~edge_sel_q) | (~f_d & f_q & edge_sel_q);

    if (wr_en) begin
      case (reg_addr_i)
        3'd0: clr_v[7:0]       = data_i;
        3'd1: clr_v[12:8]      = data_i[4:0];
        3'd2: en_d[7:0]        = data_i;
        3'd3: en_d[12:8]       = data_i[4:0];
        3'd4: edge_sel_d[7:0]  = data_i;
        3'd5: edge_sel_d[12:8] = data_i[4:0];
        3'd6: begin
          presc_d = data_i;
          cnt_d   = 8'd0;
        end
        default: ;
      endcase
    end

    // a set landing with a clear on the same edge keeps the flag
    pend_d  = (pend_q & ~clr_v) | set_v;
    irq_n_d = ~|(pend_q & en_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q     <= '0;
      en_q       <= '0;
      edge_sel_q <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      s0_q       <= '0;
      s1_q       <= '0;
      f_q        <= '0;
      irq_n_q    <= 1'b1;
    end else begin
      pend_q     <= pend_d;
      en_q       <= en_d;
      edge_sel_q <= edge_sel_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      f_q        <= f_d;
      irq_n_q    <= irq_n_d;
    end
  end

  always_comb begin
    data_o = 8'h00;
    case (reg_addr_i)
      3'd0: data_o = pend_q[7:0];
      3'd1: data_o = {3'b000, pend_q[12:8]};
      3'd2: data_o = en_q[7:0];
      3'd3: data_o = {3'b000, en_q[12:8]};
      3'd4: data_o = edge_sel_q[7:0];
      3'd5: data_o = {3'b000, edge_sel_q[12:8]};
      3'd6: data_o = presc_q;
      3'd7: data_o = {7'b0000000, ~irq_n_q};
      default: data_o = 8'h00;
    endcase
  end

  assign irq_n = irq_n_q;

endmodule

// File: tb/tb_gpio_irq.sv
// tb/tb_gpio_irq.sv - scoreboard bench for gpio_irq with directed vectors
module tb_gpio_irq;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        wr_n;
  logic [2:0]  reg_addr_i;
  logic [7:0]  data_i;
  logic        irq_cs;
  logic [7:0]  data_o;
  logic [12:0] gpio_in;
  logic        irq_n;

  gpio_irq dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_n       (wr_n),
    .reg_addr_i (reg_addr_i),
    .data_i     (data_i),
    .irq_cs     (irq_cs),
    .data_o     (data_o),
    .gpio_in    (gpio_in),
    .irq_n      (irq_n)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic [7:0] exp;
    bit         is_irq;
  } chk_t;

  chk_t q[$];
  logic chk_v = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  // monitor: drains every expectation queued for the current sample point
  always @(negedge clk_i) begin
    if (chk_v) begin
      while (q.size() > 0) begin
        chk_t e;
        logic [7:0] act;
        e = q.pop_front();
        act = e.is_irq ? {7'b0, irq_n} : data_o;
        n_chk++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    reg_addr_i = a;
    data_i     = d;
    irq_cs     = 1'b1;
    wr_n       = 1'b0;
    wait_cyc(1);
    irq_cs     = 1'b0;
    wr_n       = 1'b1;
  endtask

  task automatic chk(input logic [2:0] a, input logic [7:0] exp, input logic irq_exp,
                     input string name);
    chk_t e;
    reg_addr_i = a;
    e.name = {name, "_reg"}; e.exp = exp; e.is_irq = 1'b0; q.push_back(e);
    e.name = {name, "_irq"}; e.exp = {7'b0, irq_exp}; e.is_irq = 1'b1; q.push_back(e);
    chk_v = 1'b1;
    @(negedge clk_i);
    #1;
    chk_v = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0; wr_n = 1'b1; irq_cs = 1'b0;
    reg_addr_i = 3'd0; data_i = 8'h00; gpio_in = '0;
    wait_cyc(3);
    rst_n_i = 1'b1;
    wait_cyc(2);

    for (int a = 0; a < 8; a++) chk(a[2:0], 8'h00, 1'b1, "reset_regs");

    // rising edge on GPIO0 with P = 0
    wr(3'd2, 8'h01);
    wr(3'd0, 8'hFF);
    gpio_in[0] = 1'b1;
    wait_cyc(4);
    chk(3'd0, 8'h00, 1'b1, "rise_edge4");
    chk(3'd0, 8'h01, 1'b1, "rise_edge5");
    chk(3'd7, 8'h01, 1'b0, "rise_edge6");
    wr(3'd0, 8'h01);
    chk(3'd0, 8'h00, 1'b0, "w1c_same_edge");
    chk(3'd7, 8'h00, 1'b1, "w1c_next_edge");

    // falling edge on GPIO12
    wr(3'd5, 8'h10);
    gpio_in[12] = 1'b1;
    wait_cyc(8);
    wr(3'd3, 8'h10);
    wr(3'd1, 8'hFF);
    chk(3'd1, 8'h00, 1'b1, "hi_rise_ignored");
    gpio_in[12] = 1'b0;
    wait_cyc(8);
    chk(3'd1, 8'h10, 1'b0, "hi_fall_pend");
    wr(3'd1, 8'h10);
    gpio_in[12] = 1'b1;
    wait_cyc(8);
    chk(3'd1, 8'h00, 1'b1, "hi_rise_again");

    // debounce with P = 3
    wr(3'd6, 8'h03);
    gpio_in[5] = 1'b1;
    wait_cyc(8);
    gpio_in[5] = 1'b0;
    wait_cyc(20);
    chk(3'd0, 8'h00, 1'b1, "glitch_8cyc");
    gpio_in[5] = 1'b1;
    wait_cyc(20);
    chk(3'd0, 8'h20, 1'b1, "held_20cyc");

    // enabling an already-pending pin
    wr(3'd2, 8'h21);
    chk(3'd7, 8'h00, 1'b1, "en_same_edge");
    chk(3'd7, 8'h01, 1'b0, "en_next_edge");
    wr(3'd0, 8'h20);
    wr(3'd2, 8'h01);

    // set/clear collision on GPIO3
    wr(3'd6, 8'h00);
    gpio_in[3] = 1'b1;
    wait_cyc(4);
    wr(3'd0, 8'h08);
    chk(3'd0, 8'h08, 1'b1, "collision_set_wins");
    wr(3'd0, 8'h08);
    chk(3'd0, 8'h00, 1'b1, "collision_then_clear");

    // register map
    wr(3'd1, 8'hFF);
    wr(3'd3, 8'hFF);
    wr(3'd5, 8'hFF);
    wr(3'd7, 8'hFF);
    chk(3'd1, 8'h00, 1'b1, "map_pend_hi");
    chk(3'd3, 8'h1F, 1'b1, "map_en_hi");
    chk(3'd5, 8'h1F, 1'b1, "map_edge_hi");
    chk(3'd7, 8'h00, 1'b1, "map_status_ro");
    chk(3'd2, 8'h01, 1'b1, "map_en_lo");
    chk(3'd3, 8'h1F, 1'b1, "map_en_hi_reread");

    // reset mid-activity
    gpio_in[0] = 1'b0;
    wait_cyc(8);
    gpio_in[0] = 1'b1;
    wait_cyc(8);
    chk(3'd0, 8'h01, 1'b0, "pre_reset_pend");
    wait_cyc(1);
    rst_n_i = 1'b0;
    chk(3'd7, 8'h00, 1'b1, "async_reset_irq");
    for (int a = 0; a < 7; a++) chk(a[2:0], 8'h00, 1'b1, "in_reset_regs");
    gpio_in = '0;
    wait_cyc(1);
    rst_n_i = 1'b1;
    wait_cyc(10);
    chk(3'd7, 8'h00, 1'b1, "post_reset_status");
    chk(3'd0, 8'h00, 1'b1, "post_reset_pend");

    @(negedge clk_i);
    @(negedge clk_i);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Input-side companion to the nano-Z80 GPIO port. It takes the 13 GPIO pin levels, synchronises and debounces them, and latches selectable rising or falling edges into per-pin pending flags. It raises an active-low interrupt request to the Z80 while any enabled pin is pending. The block sits on the same I/O chip-select/register bus as the GPIO port, with its own chip select and 3-bit register address.

## Interface
- No parameters; the pin count is fixed at 13 (GPIO 0-12).
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- wr_n  in  1  active-low write strobe from the Z80 bus.
- reg_addr_i  in  3  register select.
- data_i  in  8  write data.
- irq_cs  in  1  chip select; writes occur when irq_cs && !wr_n.
- data_o  out  8  read data, combinational from reg_addr_i.
- gpio_in  in  13  raw pin levels, asynchronous to clk_i.
- irq_n  out  1  registered interrupt request, active-low.

## Operation
- Registers (addr: name, reset value):
  - 0: PEND_LO, pending flags GPIO 0-7, reset 0x00. Write-1-to-clear.
  - 1: PEND_HI, pending flags GPIO 8-12 in bits 4:0, reset 0x00. Write-1-to-clear.
  - 2: EN_LO, interrupt enable, reset 0x00.
  - 3: EN_HI, interrupt enable in bits 4:0, reset 0x00.
  - 4: EDGE_LO, edge select, 0 = rising, 1 = falling, reset 0x00.
  - 5: EDGE_HI, edge select in bits 4:0, reset 0x00.
  - 6: PRESC, debounce prescaler P, reset 0x00.
  - 7: STATUS, read-only. Bit 0 = !irq_n, bits 7:1 read 0; writes are ignored.
- HI registers: bits 7:5 read 0; writes to those bits are ignored.
- Synchroniser: two flops per pin (sync1, sync2), reset 0.
- Tick counter: 8 bits, counts 0..P.
  - tick is asserted in the cycle where count == P; the counter then wraps to 0.
  - P = 0 gives a tick every cycle.
  - A write to PRESC reloads the counter to 0.
- Debounce, per pin: 2-bit sample history s, plus filtered level f. Both reset 0.
  - On each tick: s <= {s[0], sync2}.
  - On the same tick, f <= 1 if s == 2'b11 and sync2 == 1; f <= 0 if s == 2'b00 and sync2 == 0; otherwise f holds.
  - Net rule: three consecutive equal tick samples are required for f to change.
- Edge detection: on the clock edge where f changes, the pin's pending flag is set if the direction matches EDGE (0→1 with EDGE = 0, or 1→0 with EDGE = 1).
  - Pending flags set regardless of enable; enable only gates the interrupt.
- Pending clear:
  - Writing 1 to a PEND bit clears it; writing 0 has no effect.
  - If a set and a clear hit the same cycle, the set wins and the flag stays 1.
  - A write held for multiple cycles is idempotent.
- Interrupt: irq_n <= ~|(pending & enable) on every clock; reset value 1.
- Reset mid-operation: all flops clear asynchronously and irq_n goes to 1 immediately.
  - A pin held high through reset produces a rising-edge pending after release. Software clears PEND after configuring EDGE.
- Reads have no side effects.

## Timing
- Register writes take effect on the clock edge where irq_cs && !wr_n is sampled.
- data_o reflects the new value after that edge; it is combinational from the registers and reg_addr_i.
- Pin-to-interrupt latency with P = 0, counting edge 1 as the first edge that samples the pin change into sync1:
  - sync2 valid after edge 2.
  - f and pending update on edge 5.
  - irq_n falls on edge 6.
- With P > 0, f updates on the 3rd tick after sync2 changes. Total latency is 2 + 3 × (P+1) + 1 edges, minus tick phase, worst case.
- Glitches shorter than 3 tick periods never change f and never set pending.
- Enabling a pin whose flag is already pending drives irq_n low one edge after the EN write.
- Clearing the last enabled pending flag releases irq_n one edge after the PEND write.

## Test plan
- Reset: assert rst_n_i mid-activity → all registers read 0x00 and irq_n = 1 asynchronously. After release with gpio_in = 0, STATUS stays 0x00.
- Rising-edge interrupt: P = 0, EN_LO = 0x01, PEND cleared, GPIO0 goes 0→1 → PEND_LO = 0x01 after edge 5, irq_n low at edge 6. Writing 0x01 to PEND_LO → irq_n high on the next edge.
- Falling edge and high bank: EDGE_HI = 0x10, EN_HI = 0x10, GPIO12 goes 1→0 → PEND_HI = 0x10 and irq_n = 0. A 0→1 transition on GPIO12 sets nothing.
- Debounce: P = 3, GPIO5 pulses high for 8 cycles → PEND_LO stays 0x00. Holding it high for 20 cycles → PEND_LO = 0x20 (EN = 0), and irq_n stays 1.
- Set/clear collision: arrange for GPIO3's pending set to land on the same edge as a PEND_LO write of 0x08 → PEND_LO bit 3 = 1 afterwards.
- Register map: write 0xFF to addresses 1, 3 and 5 → each reads back 0x1F (except PEND_HI, which reads 0x00). A write to address 7 is ignored, and reads have no side effects.
